key_click_decoder: RTL and testbench

- Sits directly downstream of the debounced key-capture stage.
- Consumes its one-cycle press pulse and groups presses that fall within a time window into single, double or triple click events.
- Buffers decoded events in a small FIFO and presents them on a valid/ready interface.
- The consumer is the control logic that triggers UDP test actions, e.g. send packet or toggle stream.

---
 rtl/key_click_pkg.sv | 27 ++
 rtl/key_evt_fifo.sv | 57 +++++
 rtl/key_click_decoder.sv | 152 +++++++++++++++
 tb/tb_key_click_decoder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/key_click_pkg.sv
// rtl/key_click_pkg.sv - shared state type, event codes and width helpers for the key click decoder
package key_click_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      EMIT  = 2'd2
   } click_state_t;

   localparam logic [1:0] EVT_SINGLE = 2'd1;
   localparam logic [1:0] EVT_DOUBLE = 2'd2;
   localparam logic [1:0] EVT_TRIPLE = 2'd3;

   function automatic int presc_w(input int clk_freq);
      return $clog2(clk_freq / 1000);
   endfunction

   function automatic int ms_w(input int window_ms);
      return $clog2(window_ms + 1);
   endfunction

   // Extra MSB is the wrap bit that separates full from empty.
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// rtl/key_evt_fifo.sv - synchronous event FIFO with registered head data and valid
module key_evt_fifo
   import key_click_pkg::*;
#(
   parameter int WIDTH = 2,
   parameter int DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             valid_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int PW = ptr_w(DEPTH);
   localparam int AW = PW - 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr, wr_nxt, rd_nxt, count;
   logic             do_wr, do_rd;

   assign count   = wr_ptr - rd_ptr;
   assign full_o  = (count == PW'(DEPTH));
   assign empty_o = (count == '0);
   assign do_rd   = rd_en_i && !empty_o;
   assign do_wr   = wr_en_i && (!full_o || do_rd);
   assign wr_nxt  = wr_ptr + PW'(do_wr);
   assign rd_nxt  = rd_ptr + PW'(do_rd);

   always_ff @(posedge clk_i) begin
      if (do_wr)
         mem[wr_ptr[AW-1:0]] <= wr_data_i;
   end

   // Head register tracks the next-cycle head; a write into an empty FIFO lands here directly.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         valid_o   <= 1'b0;
         rd_data_o <= '0;
      end else begin
         wr_ptr  <= wr_nxt;
         rd_ptr  <= rd_nxt;
         valid_o <= (wr_nxt != rd_nxt);
         if (do_wr && (wr_ptr[AW-1:0] == rd_nxt[AW-1:0]))
            rd_data_o <= wr_data_i;
         else
            rd_data_o <= mem[rd_nxt[AW-1:0]];
      end
   end

endmodule

// File: rtl/key_click_decoder.sv
// rtl/key_click_decoder.sv - groups key presses into 1/2/3-click events; KEY_CLICK_TS_EN adds first-press ms timestamps
module key_click_decoder
   import key_click_pkg::*;
#(
   parameter int CLK_FREQ   = 100000000,
   parameter int WINDOW_MS  = 300,
   parameter int MAX_CLICKS = 3,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        key_cap_i,
   output logic        evt_valid_o,
   input  logic        evt_ready_i,
   output logic [1:0]  evt_code_o,
`ifdef KEY_CLICK_TS_EN
   output logic [15:0] evt_ts_o,
`endif
   output logic        evt_ovf_o,
   input  logic        ovf_clr_i
);

   localparam int PRESC_W = presc_w(CLK_FREQ);
   localparam int MS_W    = ms_w(WINDOW_MS);
   localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_FREQ / 1000 - 1);
   localparam logic [MS_W-1:0]    MS_LAST   = MS_W'(WINDOW_MS - 1);
   localparam logic [1:0]         CLICK_MAX = 2'(MAX_CLICKS);

   click_state_t       state;
   logic [1:0]         click_cnt;
   logic [PRESC_W-1:0] presc;
   logic [MS_W-1:0]    ms_cnt;
   logic               ms_tick, expiry, push, pop, drop;
   logic               fifo_full, fifo_empty;

   assign ms_tick = (state == COUNT) && (presc == PRESC_MAX);
   assign expiry  = ms_tick && (ms_cnt == MS_LAST);
   assign push    = (state == EMIT);
   assign pop     = evt_ready_i && !fifo_empty;
   assign drop    = push && fifo_full && !pop;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= IDLE;
         click_cnt <= '0;
         presc     <= '0;
         ms_cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (key_cap_i) begin
                  click_cnt <= EVT_SINGLE;
                  presc     <= '0;
                  ms_cnt    <= '0;
                  state     <= COUNT;
               end
            end
            COUNT: begin
               // A press on the expiry cycle takes priority and restarts the window.
               if (key_cap_i) begin
                  click_cnt <= click_cnt + 2'd1;
                  presc     <= '0;
                  ms_cnt    <= '0;
                  if (click_cnt + 2'd1 == CLICK_MAX)
                     state <= EMIT;
               end else begin
                  if (ms_tick) begin
                     presc  <= '0;
                     ms_cnt <= ms_cnt + MS_W'(1);
                  end else begin
                     presc <= presc + PRESC_W'(1);
                  end
                  if (expiry)
                     state <= EMIT;
               end
            end
            EMIT: begin
               if (key_cap_i) begin
                  click_cnt <= EVT_SINGLE;
                  presc     <= '0;
                  ms_cnt    <= '0;
                  state     <= COUNT;
               end else begin
                  click_cnt <= '0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         evt_ovf_o <= 1'b0;
      else if (drop)
         evt_ovf_o <= 1'b1;
      else if (ovf_clr_i)
         evt_ovf_o <= 1'b0;
   end

`ifdef KEY_CLICK_TS_EN
   localparam int EVT_W = 18;
   logic [PRESC_W-1:0] ts_presc;
   logic [15:0]        ts_ms, ts_first;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ts_presc <= '0;
         ts_ms    <= '0;
         ts_first <= '0;
      end else begin
         if (ts_presc == PRESC_MAX) begin
            ts_presc <= '0;
            ts_ms    <= ts_ms + 16'd1;
         end else begin
            ts_presc <= ts_presc + PRESC_W'(1);
         end
         if (key_cap_i && (state == IDLE || state == EMIT))
            ts_first <= ts_ms;
      end
   end
`else
   localparam int EVT_W = 2;
`endif

   logic [EVT_W-1:0] push_data, pop_data;

`ifdef KEY_CLICK_TS_EN
   assign push_data              = {ts_first, click_cnt};
   assign {evt_ts_o, evt_code_o} = pop_data;
`else
   assign push_data  = click_cnt;
   assign evt_code_o = pop_data;
`endif

   key_evt_fifo #(
      .WIDTH (EVT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .wr_en_i   (push),
      .wr_data_i (push_data),
      .rd_en_i   (pop),
      .rd_data_o (pop_data),
      .valid_o   (evt_valid_o),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

endmodule

// File: tb/tb_key_click_decoder.sv
// tb/tb_key_click_decoder.sv - scoreboard bench for key_click_decoder at 100 cycles/ms, 5 ms window
module tb_key_click_decoder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        key_cap = 1'b0;
   logic        evt_ready = 1'b0;
   logic        ovf_clr = 1'b0;
   logic        evt_valid;
   logic [1:0]  evt_code;
   logic        evt_ovf;
`ifdef KEY_CLICK_TS_EN
   logic [15:0] evt_ts;
`endif

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int t0;

   typedef struct {
      int cyc;
      int code;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      int p0, p1, p2, p3;
      int ne;
      int c0, k0, c1, k1;
      int len;
   } vec_t;
   vec_t vecs[6];

   key_click_decoder #(
      .CLK_FREQ   (100000),
      .WINDOW_MS  (5),
      .MAX_CLICKS (3),
      .FIFO_DEPTH (4)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .key_cap_i   (key_cap),
      .evt_valid_o (evt_valid),
      .evt_ready_i (evt_ready),
      .evt_code_o  (evt_code),
`ifdef KEY_CLICK_TS_EN
      .evt_ts_o    (evt_ts),
`endif
      .evt_ovf_o   (evt_ovf),
      .ovf_clr_i   (ovf_clr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && evt_valid && evt_ready) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_event: got code %0d at cycle %0d expected none", evt_code, cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("evt_code", int'(evt_code), e.code);
            if (e.cyc >= 0)
               check("evt_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      key_cap = 1'b0;
      ovf_clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic run_cycles(input int n);
      for (int r = 0; r < n; r++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      vecs[0] = '{10,  -1,  -1,  -1, 1,  512, 1,   -1, 0,  700};
      vecs[1] = '{10, 300,  -1,  -1, 1,  802, 2,   -1, 0, 1000};
      vecs[2] = '{10, 200, 400, 450, 2,  402, 3,  952, 1, 1100};
      vecs[3] = '{10, 510,  -1,  -1, 1, 1012, 2,   -1, 0, 1200};
      vecs[4] = '{10, 509,  -1,  -1, 1, 1011, 2,   -1, 0, 1200};
      vecs[5] = '{10, 511,  -1,  -1, 2,  512, 1, 1013, 1, 1200};

      @(posedge clk);
      #1;
      check("reset_valid", int'(evt_valid), 0);
      check("reset_code", int'(evt_code), 0);
      check("reset_ovf", int'(evt_ovf), 0);

      // Table-driven single-group scenarios with the consumer always ready.
      for (int i = 0; i < 6; i++) begin
         do_reset();
         evt_ready = 1'b1;
         @(posedge clk);
         #1;
         t0 = cyc;
         sb.push_back('{t0 + vecs[i].c0, vecs[i].k0});
         if (vecs[i].ne > 1)
            sb.push_back('{t0 + vecs[i].c1, vecs[i].k1});
         for (int r = 0; r < vecs[i].len; r++) begin
            key_cap = (r == vecs[i].p0) || (r == vecs[i].p1) ||
                      (r == vecs[i].p2) || (r == vecs[i].p3);
            @(posedge clk);
            #1;
         end
         key_cap = 1'b0;
         check("vec_drained", sb.size(), 0);
         sb.delete();
         check("vec_ovf", int'(evt_ovf), 0);
      end

      // Overflow: five singles into a 4-deep FIFO with the consumer stalled.
      do_reset();
      evt_ready = 1'b0;
      @(posedge clk);
      #1;
      for (int r = 0; r < 4600; r++) begin
         key_cap = (r % 1000 == 10) && (r < 4100);
         if (r == 4511) check("ovf_before_drop", int'(evt_ovf), 0);
         if (r == 4512) check("ovf_after_drop", int'(evt_ovf), 1);
         @(posedge clk);
         #1;
      end
      key_cap = 1'b0;
      check("full_valid", int'(evt_valid), 1);
      check("full_code", int'(evt_code), 1);
      for (int k = 0; k < 4; k++)
         sb.push_back('{-1, 1});
      evt_ready = 1'b1;
      run_cycles(10);
      check("ovf_pops_drained", sb.size(), 0);
      sb.delete();
      check("ovf_valid_empty", int'(evt_valid), 0);
      check("ovf_sticky", int'(evt_ovf), 1);
      ovf_clr = 1'b1;
      @(posedge clk);
      #1;
      ovf_clr = 1'b0;
      check("ovf_cleared", int'(evt_ovf), 0);

      // Reset with two triples buffered and a group open.
      do_reset();
      evt_ready = 1'b0;
      @(posedge clk);
      #1;
      for (int r = 0; r < 250; r++) begin
         key_cap = (r == 10) || (r == 20) || (r == 30) || (r == 40) ||
                   (r == 50) || (r == 60) || (r == 100);
         if (r == 240) begin
            check("pre_rst_valid", int'(evt_valid), 1);
            check("pre_rst_code", int'(evt_code), 3);
         end
         @(posedge clk);
         #1;
      end
      key_cap = 1'b0;
      rst = 1'b1;
      #1;
      check("async_rst_valid", int'(evt_valid), 0);
      check("async_rst_code", int'(evt_code), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      evt_ready = 1'b1;
      run_cycles(1200);
      check("post_rst_valid", int'(evt_valid), 0);
      check("post_rst_no_events", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
